fetch_sequencer: RTL and testbench

Parametrised program-sequencing block for the accumulator processor: program counter, branch-target lookup table, return-address stack, run/halt state machine and execution counters. It replaces the fixed PC plus free-standing cycle counter in the processor top level. It adds relative branches, table-driven absolute branches, call/return, and stall support. It sits between the control decoder (branch/call/return/halt requests) and the instruction ROM (`pc`).

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/ret_stack.sv | 45 ++++
 rtl/fetch_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the fetch sequencer and its return-address stack.
package fetch_pkg;

    localparam int PCW_DEF   = 16;
    localparam int OFFW_DEF  = 8;
    localparam int LUT_D_DEF = 16;
    localparam int RAS_D_DEF = 4;
    localparam int CNTW_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        RUN,
        HALT
    } state_t;

    typedef enum logic [2:0] {
        PC_HOLD,
        PC_INC,
        PC_RET,
        PC_LUT,
        PC_REL,
        PC_ZERO
    } pc_sel_t;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO; data shows the top entry (zero when empty), push is ignored when full.
module ret_stack #(
    parameter int W = 16,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] data,
    output logic         full,
    output logic         empty
);

    localparam int AW = (D > 1) ? $clog2(D) : 1;
    localparam int CW = $clog2(D + 1);

    logic [W-1:0]  mem [D];
    logic [CW-1:0] count;

    assign full  = (count == CW'(D));
    assign empty = (count == '0);
    assign data  = empty ? '0 : mem[AW'(count - 1'b1)];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            for (int unsigned i = 0; i < unsigned'(D); i++) begin
                mem[AW'(i)] <= '0;
            end
        end else if (clear) begin
            count <= '0;
        end else if (push && !full) begin
            mem[AW'(count)] <= push_data;
            count           <= count + 1'b1;
        end else if (pop && !empty) begin
            count <= count - 1'b1;
        end
    end

    a_no_push_pop : assert property (@(posedge clk) disable iff (!rst_n) !(push && pop));

endmodule

// File: rtl/fetch_sequencer.sv
// Program sequencer: PC, branch-target LUT, return-address stack, run/halt FSM and
// saturating execution counters.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter  int PCW   = PCW_DEF,
    parameter  int OFFW  = OFFW_DEF,
    parameter  int LUT_D = LUT_D_DEF,
    parameter  int RAS_D = RAS_D_DEF,
    parameter  int CNTW  = CNTW_DEF,
    localparam int LIW   = $clog2(LUT_D)
) (
    input  logic            CLK,
    input  logic            reset_n,
    input  logic            start,
    input  logic            stall,
    input  logic            taken,
    input  logic            br_rel,
    input  logic            br_abs,
    input  logic            call,
    input  logic            ret,
    input  logic            halt_req,
    input  logic [OFFW-1:0] br_offset,
    input  logic [LIW-1:0]  br_idx,
    input  logic            lut_we,
    input  logic [LIW-1:0]  lut_waddr,
    input  logic [PCW-1:0]  lut_wdata,
    output logic [PCW-1:0]  pc,
    output logic            halt,
    output logic [CNTW-1:0] cycle_ct,
    output logic [CNTW-1:0] instr_ct,
    output logic [CNTW-1:0] stall_ct,
    output logic            ras_err
);

    state_t  state, state_next;
    pc_sel_t pc_sel;

    logic [PCW-1:0] lut [LUT_D];
    logic [PCW-1:0] lut_rdata;
    logic [PCW-1:0] pc_inc;
    logic [PCW-1:0] off_ext;
    logic [PCW-1:0] pc_next;
    logic [PCW-1:0] ras_top;

    logic ras_push, ras_pop, ras_clear, ras_full, ras_empty;
    logic clr, err_set;
    logic inc_cycle, inc_instr, inc_stall;

    assign lut_rdata = lut[br_idx];
    assign pc_inc    = pc + 1'b1;
    assign off_ext   = PCW'($signed(br_offset));

    ret_stack #(
        .W (PCW),
        .D (RAS_D)
    ) u_ras (
        .clk       (CLK),
        .rst_n     (reset_n),
        .clear     (ras_clear),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_inc),
        .data      (ras_top),
        .full      (ras_full),
        .empty     (ras_empty)
    );

    // start overrides every state; request decoding applies only to unstalled RUN cycles.
    always_comb begin
        state_next = state;
        pc_sel     = PC_HOLD;
        ras_push   = 1'b0;
        ras_pop    = 1'b0;
        ras_clear  = 1'b0;
        err_set    = 1'b0;
        clr        = 1'b0;
        inc_cycle  = 1'b0;
        inc_instr  = 1'b0;
        inc_stall  = 1'b0;

        if (start) begin
            state_next = INIT;
            pc_sel     = PC_ZERO;
            clr        = 1'b1;
            ras_clear  = 1'b1;
        end else begin
            unique case (state)
                INIT: state_next = RUN;
                RUN: begin
                    inc_cycle = 1'b1;
                    if (stall) begin
                        inc_stall = 1'b1;
                    end else begin
                        inc_instr = 1'b1;
                        if (halt_req) begin
                            state_next = HALT;
                        end else if (ret) begin
                            if (ras_empty) begin
                                pc_sel  = PC_INC;
                                err_set = 1'b1;
                            end else begin
                                pc_sel  = PC_RET;
                                ras_pop = 1'b1;
                            end
                        end else if (call) begin
                            pc_sel = PC_LUT;
                            if (ras_full) begin
                                err_set = 1'b1;
                            end else begin
                                ras_push = 1'b1;
                            end
                        end else if (br_abs && taken) begin
                            pc_sel = PC_LUT;
                        end else if (br_rel && taken) begin
                            pc_sel = PC_REL;
                        end else begin
                            pc_sel = PC_INC;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        pc_next = pc;
        unique case (pc_sel)
            PC_INC:  pc_next = pc_inc;
            PC_RET:  pc_next = ras_top;
            PC_LUT:  pc_next = lut_rdata;
            PC_REL:  pc_next = pc + off_ext;
            PC_ZERO: pc_next = '0;
            default: pc_next = pc;
        endcase
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            pc      <= '0;
            halt    <= 1'b1;
            ras_err <= 1'b0;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            halt    <= (state_next == IDLE) || (state_next == HALT);
            ras_err <= clr ? 1'b0 : (ras_err | err_set);
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            cycle_ct <= '0;
            instr_ct <= '0;
            stall_ct <= '0;
        end else if (clr) begin
            cycle_ct <= '0;
            instr_ct <= '0;
            stall_ct <= '0;
        end else begin
            if (inc_cycle && (cycle_ct != '1)) cycle_ct <= cycle_ct + 1'b1;
            if (inc_instr && (instr_ct != '1)) instr_ct <= instr_ct + 1'b1;
            if (inc_stall && (stall_ct != '1)) stall_ct <= stall_ct + 1'b1;
        end
    end

    // Reads use the pre-edge contents, so a same-cycle write to the read index returns the old entry.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < unsigned'(LUT_D); i++) begin
                lut[LIW'(i)] <= '0;
            end
        end else if (lut_we) begin
            lut[lut_waddr] <= lut_wdata;
        end
    end

    a_halt_state : assert property (@(posedge CLK) disable iff (!reset_n)
        halt == ((state == IDLE) || (state == HALT)));

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed vector bench for fetch_sequencer with default parameters.
module tb_fetch_sequencer;

    typedef struct {
        logic        start, stall, taken, br_rel, br_abs, call, ret, halt_req;
        logic        lut_we;
        logic [3:0]  lut_waddr;
        logic [15:0] lut_wdata;
        logic [7:0]  off;
        logic [3:0]  idx;
        logic [15:0] exp_pc;
        logic        exp_halt;
        logic        exp_err;
    } vec_t;

    localparam logic [7:0] ST = 8'h01, SL = 8'h02, TK = 8'h04, RL = 8'h08;
    localparam logic [7:0] AB = 8'h10, CL = 8'h20, RT = 8'h40, HQ = 8'h80;

    logic        CLK = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0, stall = 1'b0, taken = 1'b0, br_rel = 1'b0, br_abs = 1'b0;
    logic        call = 1'b0, ret = 1'b0, halt_req = 1'b0, lut_we = 1'b0;
    logic [7:0]  br_offset = '0;
    logic [3:0]  br_idx = '0, lut_waddr = '0;
    logic [15:0] lut_wdata = '0;
    logic [15:0] pc, cycle_ct, instr_ct, stall_ct;
    logic        halt, ras_err;

    int checks = 0;
    int errors = 0;
    vec_t vq[$];

    always #5 CLK = ~CLK;

    fetch_sequencer dut (
        .CLK       (CLK),
        .reset_n   (reset_n),
        .start     (start),
        .stall     (stall),
        .taken     (taken),
        .br_rel    (br_rel),
        .br_abs    (br_abs),
        .call      (call),
        .ret       (ret),
        .halt_req  (halt_req),
        .br_offset (br_offset),
        .br_idx    (br_idx),
        .lut_we    (lut_we),
        .lut_waddr (lut_waddr),
        .lut_wdata (lut_wdata),
        .pc        (pc),
        .halt      (halt),
        .cycle_ct  (cycle_ct),
        .instr_ct  (instr_ct),
        .stall_ct  (stall_ct),
        .ras_err   (ras_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [15:0] cyc, input logic [15:0] ins,
                           input logic [15:0] stl);
        chk({tag, "_cycle_ct"}, {16'h0, cycle_ct}, {16'h0, cyc});
        chk({tag, "_instr_ct"}, {16'h0, instr_ct}, {16'h0, ins});
        chk({tag, "_stall_ct"}, {16'h0, stall_ct}, {16'h0, stl});
    endtask

    function automatic vec_t mk(input logic [7:0] r, input logic [7:0] off, input logic [3:0] idx,
                                input logic [15:0] epc, input logic eh, input logic ee);
        vec_t v;
        v.start = r[0]; v.stall = r[1]; v.taken = r[2]; v.br_rel = r[3];
        v.br_abs = r[4]; v.call = r[5]; v.ret = r[6]; v.halt_req = r[7];
        v.lut_we = 1'b0; v.lut_waddr = '0; v.lut_wdata = '0;
        v.off = off; v.idx = idx;
        v.exp_pc = epc; v.exp_halt = eh; v.exp_err = ee;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        start = v.start; stall = v.stall; taken = v.taken; br_rel = v.br_rel;
        br_abs = v.br_abs; call = v.call; ret = v.ret; halt_req = v.halt_req;
        lut_we = v.lut_we; lut_waddr = v.lut_waddr; lut_wdata = v.lut_wdata;
        br_offset = v.off; br_idx = v.idx;
        @(posedge CLK);
        #1;
        start = 0; stall = 0; taken = 0; br_rel = 0; br_abs = 0;
        call = 0; ret = 0; halt_req = 0; lut_we = 0;
    endtask

    task automatic lut_write(input logic [3:0] a, input logic [15:0] d);
        lut_we = 1'b1; lut_waddr = a; lut_wdata = d;
        @(posedge CLK);
        #1;
        lut_we = 1'b0;
    endtask

    initial begin
        vec_t v;

        // start for 2 cycles, INIT->RUN, then free run 0->5
        vq.push_back(mk(ST, 8'h00, 4'd0, 16'h0000, 0, 0));
        vq.push_back(mk(ST, 8'h00, 4'd0, 16'h0000, 0, 0));
        vq.push_back(mk(8'h00, 8'h00, 4'd0, 16'h0000, 0, 0));
        for (int k = 1; k <= 5; k++) vq.push_back(mk(8'h00, 8'h00, 4'd0, 16'(k), 0, 0));
        // absolute and relative branches
        vq.push_back(mk(AB, 8'h00, 4'd3, 16'h0006, 0, 0));          // v8 not taken
        vq.push_back(mk(AB | TK, 8'h00, 4'd3, 16'h0040, 0, 0));     // v9
        vq.push_back(mk(AB | TK, 8'h00, 4'd1, 16'h000A, 0, 0));     // v10
        vq.push_back(mk(RL | TK, 8'hFC, 4'd0, 16'h0006, 0, 0));     // v11 10-4
        vq.push_back(mk(RL, 8'hFC, 4'd0, 16'h0007, 0, 0));          // v12 not taken
        vq.push_back(mk(AB | TK, 8'h00, 4'd2, 16'hFFFE, 0, 0));     // v13
        vq.push_back(mk(RL | TK, 8'h03, 4'd0, 16'h0001, 0, 0));     // v14 wrap
        vq.push_back(mk(8'h00, 8'h00, 4'd0, 16'h0002, 0, 0));       // v15
        v = mk(AB | TK, 8'h00, 4'd9, 16'h0000, 0, 0);                // v16 old LUT entry
        v.lut_we = 1'b1; v.lut_waddr = 4'd9; v.lut_wdata = 16'h0777;
        vq.push_back(v);
        vq.push_back(mk(AB | TK, 8'h00, 4'd9, 16'h0777, 0, 0));     // v17
        // call depth 5 into a 4-deep stack, then 5 returns
        vq.push_back(mk(CL, 8'h00, 4'd4, 16'h0100, 0, 0));          // v18 push 0778
        vq.push_back(mk(CL, 8'h00, 4'd5, 16'h0200, 0, 0));          // v19 push 0101
        vq.push_back(mk(CL, 8'h00, 4'd6, 16'h0300, 0, 0));          // v20 push 0201
        vq.push_back(mk(CL, 8'h00, 4'd7, 16'h0400, 0, 0));          // v21 push 0301
        vq.push_back(mk(CL, 8'h00, 4'd8, 16'h0500, 0, 1));          // v22 overflow
        vq.push_back(mk(RT, 8'h00, 4'd0, 16'h0301, 0, 1));          // v23
        vq.push_back(mk(RT, 8'h00, 4'd0, 16'h0201, 0, 1));
        vq.push_back(mk(RT, 8'h00, 4'd0, 16'h0101, 0, 1));
        vq.push_back(mk(RT, 8'h00, 4'd0, 16'h0778, 0, 1));          // v26
        vq.push_back(mk(RT, 8'h00, 4'd0, 16'h0779, 0, 1));          // v27 underflow
        // stall with ignored requests, then halt priority over ret
        for (int k = 0; k < 3; k++) vq.push_back(mk(SL | RT | CL, 8'h00, 4'd4, 16'h0779, 0, 1));
        vq.push_back(mk(HQ | RT, 8'h00, 4'd0, 16'h0779, 1, 1));     // v31
        vq.push_back(mk(8'h00, 8'h00, 4'd0, 16'h0779, 1, 1));       // v32
        vq.push_back(mk(RL | TK, 8'h05, 4'd0, 16'h0779, 1, 1));     // v33
        vq.push_back(mk(ST, 8'h00, 4'd0, 16'h0000, 0, 0));          // v34 restart
        vq.push_back(mk(8'h00, 8'h00, 4'd0, 16'h0000, 0, 0));       // v35
        v = mk(8'h00, 8'h00, 4'd0, 16'h0001, 0, 0);                  // v36
        v.lut_we = 1'b1; v.lut_waddr = 4'd10; v.lut_wdata = 16'h0020;
        vq.push_back(v);
        vq.push_back(mk(AB | TK, 8'h00, 4'd10, 16'h0020, 0, 0));    // v37

        // reset state
        #1 reset_n = 1'b0;
        #10;
        chk("rst_pc", {16'h0, pc}, 32'h0);
        chk("rst_halt", {31'h0, halt}, 32'h1);
        chk("rst_err", {31'h0, ras_err}, 32'h0);
        chk_cnt("rst", 16'h0, 16'h0, 16'h0);
        @(negedge CLK);
        reset_n = 1'b1;
        @(posedge CLK);
        #1;

        lut_write(4'd1, 16'h000A);
        lut_write(4'd2, 16'hFFFE);
        lut_write(4'd3, 16'h0040);
        lut_write(4'd4, 16'h0100);
        lut_write(4'd5, 16'h0200);
        lut_write(4'd6, 16'h0300);
        lut_write(4'd7, 16'h0400);
        lut_write(4'd8, 16'h0500);
        chk("idle_pc", {16'h0, pc}, 32'h0);
        chk("idle_halt", {31'h0, halt}, 32'h1);

        for (int i = 0; i < vq.size(); i++) begin
            apply(vq[i]);
            chk($sformatf("v%0d_pc", i), {16'h0, pc}, {16'h0, vq[i].exp_pc});
            chk($sformatf("v%0d_halt", i), {31'h0, halt}, {31'h0, vq[i].exp_halt});
            chk($sformatf("v%0d_err", i), {31'h0, ras_err}, {31'h0, vq[i].exp_err});
            if (i == 7)  chk_cnt("run5", 16'd5, 16'd5, 16'd0);
            if (i == 27) chk_cnt("calls", 16'd25, 16'd25, 16'd0);
            if (i == 30) chk_cnt("stall3", 16'd28, 16'd25, 16'd3);
            if (i == 31) chk_cnt("halt", 16'd29, 16'd26, 16'd3);
            if (i == 33) chk_cnt("frozen", 16'd29, 16'd26, 16'd3);
            if (i == 35) chk_cnt("restart", 16'd0, 16'd0, 16'd0);
        end

        // asynchronous reset mid-run at pc=0x20
        #2 reset_n = 1'b0;
        #1;
        chk("arst_pc", {16'h0, pc}, 32'h0);
        chk("arst_halt", {31'h0, halt}, 32'h1);
        chk_cnt("arst", 16'h0, 16'h0, 16'h0);
        @(negedge CLK);
        reset_n = 1'b1;

        // LUT was cleared by reset
        @(posedge CLK);
        #1;
        apply(mk(ST, 8'h00, 4'd0, 16'h0000, 0, 0));
        apply(mk(8'h00, 8'h00, 4'd0, 16'h0000, 0, 0));
        apply(mk(AB | TK, 8'h00, 4'd3, 16'h0000, 0, 0));
        chk("lut_cleared_pc", {16'h0, pc}, 32'h0);

        // counter saturation under a long stall
        stall = 1'b1;
        for (int k = 0; k < 65540; k++) begin
            @(posedge CLK);
        end
        #1;
        stall = 1'b0;
        chk_cnt("sat", 16'hFFFF, 16'd1, 16'hFFFF);
        chk("sat_pc", {16'h0, pc}, 32'h0);
        apply(mk(8'h00, 8'h00, 4'd0, 16'h0001, 0, 0));
        chk_cnt("sat_hold", 16'hFFFF, 16'd2, 16'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
